// File: rtl/synapse_accumulator.sv
// Per-neuron synaptic integrator: captures spikes against a programmable
// (address, weight) table and emits one saturated weight sum per timestep.
module synapse_accumulator #(
    parameter int NUM_CONN = 16,
    parameter int ADDR_W   = 12,
    parameter int WEIGHT_W = 16,
    parameter int ACC_W    = 24,
    parameter int IDX_W    = $clog2(NUM_CONN)
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                cfg_en,
    input  logic                spike_valid,
    input  logic [ADDR_W-1:0]   spike_addr,
    input  logic                ts_end,
    output logic [ACC_W-1:0]    acc_out,
    output logic                acc_valid,
    input  logic                acc_ready,
    output logic                sat,
    output logic                busy,
    output logic                ts_overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    localparam logic [IDX_W:0]   LAST_CNT = (IDX_W+1)'(NUM_CONN);
    localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    state_t state, state_next;

    logic [ADDR_W-1:0]   tbl_addr   [NUM_CONN];
    logic [WEIGHT_W-1:0] tbl_weight [NUM_CONN];
    logic [NUM_CONN-1:0] tbl_en;
    logic [NUM_CONN-1:0] incoming_mask;
    logic [NUM_CONN-1:0] active_mask;
    logic [NUM_CONN-1:0] spike_hit;
    logic [NUM_CONN-1:0] cfg_clear;

    logic [IDX_W:0]      scan_cnt;
    logic [ACC_W-1:0]    acc;
    logic                sat_flag;

    logic                cfg_ok;
    logic                ts_start;
    logic [WEIGHT_W-1:0] sel_weight;
    logic                sel_hit;
    logic [ACC_W:0]      sum;
    logic                overflow;
    logic [ACC_W-1:0]    sat_val;

    assign cfg_ok   = cfg_we && (state == IDLE) && !ts_end && ({1'b0, cfg_idx} < LAST_CNT);
    assign ts_start = ts_end && (state == IDLE);
    assign busy     = (state != IDLE);

    always_comb begin
        spike_hit = '0;
        cfg_clear = '0;
        for (int i = 0; i < NUM_CONN; i++) begin
            spike_hit[i] = spike_valid && tbl_en[i] && (tbl_addr[i] == spike_addr);
            cfg_clear[i] = cfg_ok && (cfg_idx == IDX_W'(i));
        end
    end

    // Entry selected by the scan counter; disabled entries never contribute.
    always_comb begin
        sel_weight = '0;
        sel_hit    = 1'b0;
        for (int i = 0; i < NUM_CONN; i++) begin
            if (scan_cnt == (IDX_W+1)'(i)) begin
                sel_weight = tbl_weight[i];
                sel_hit    = active_mask[i] && tbl_en[i];
            end
        end
    end

    // One guard bit: overflow shows as disagreement between the top two bits.
    always_comb begin
        sum      = {acc[ACC_W-1], acc}
                 + {{(ACC_W-WEIGHT_W+1){sel_weight[WEIGHT_W-1]}}, sel_weight};
        overflow = sum[ACC_W] ^ sum[ACC_W-1];
        sat_val  = overflow ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
    end

    // NOTE: the table is a small register array that must come out of reset
    // disabled, so it is reset like ordinary state rather than left as RAM.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NUM_CONN; i++) begin
                tbl_addr[i]   <= '0;
                tbl_weight[i] <= '0;
            end
            tbl_en <= '0;
        end else begin
            for (int i = 0; i < NUM_CONN; i++) begin
                if (cfg_clear[i]) begin
                    tbl_addr[i]   <= cfg_addr;
                    tbl_weight[i] <= cfg_weight;
                    tbl_en[i]     <= cfg_en;
                end
            end
        end
    end

    // A spike coincident with the boundary lands in the freshly cleared mask.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            incoming_mask <= '0;
            active_mask   <= '0;
        end else if (ts_start) begin
            active_mask   <= incoming_mask;
            incoming_mask <= spike_hit;
        end else begin
            incoming_mask <= (incoming_mask | spike_hit) & ~cfg_clear;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the next-state logic below is purely combinational.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ts_end) state_next = SCAN;
            SCAN:    if (scan_cnt == LAST_CNT) state_next = HOLD;
            HOLD:    if (acc_valid && acc_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            scan_cnt   <= '0;
            acc        <= '0;
            sat_flag   <= 1'b0;
            acc_out    <= '0;
            acc_valid  <= 1'b0;
            sat        <= 1'b0;
            ts_overrun <= 1'b0;
        end else begin
            if (ts_end && state != IDLE) ts_overrun <= 1'b1;
            case (state)
                IDLE: begin
                    if (ts_end) begin
                        acc      <= '0;
                        scan_cnt <= '0;
                        sat_flag <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scan_cnt == LAST_CNT) begin
                        acc_out   <= acc;
                        sat       <= sat_flag;
                        acc_valid <= 1'b1;
                    end else begin
                        if (sel_hit) begin
                            acc      <= sat_val;
                            sat_flag <= sat_flag | overflow;
                        end
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (acc_ready) acc_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
